// File: rtl/poly_ram_reader.sv
// Drains len RAM words from base_addr (wrap at DEPTH) as a valid/ready stream; first m_valid 3 cycles after start.
// Reads stall on m_ready backpressure (2-entry buffer + in-flight credit); POLY_RAM_READER_BITREV_EN selects bit-reversed order.
module poly_ram_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  in_flight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  vld_q;
  logic                  push, pop;
  logic [2:0]            credit;
  logic                  launch;

  assign launch = (state_q == S_IDLE) && start;

`ifdef POLY_RAM_READER_BITREV_EN
  logic [ADDR_WIDTH-1:0] base_q, off_q, off_rev;

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("poly_ram_reader: bit-reversed order needs DEPTH == 2**ADDR_WIDTH");
  end

  always_comb begin
    off_rev = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) off_rev[i] = off_q[ADDR_WIDTH-1-i];
  end

  // Power-of-two depth, so the natural adder overflow is the wrap.
  assign rd_addr = base_q + off_rev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      off_q  <= '0;
    end else if (launch) begin
      base_q <= base_addr;
      off_q  <= '0;
    end else if (ram_en) begin
      off_q  <= off_q + ADDR_WIDTH'(1);
    end
  end
`else
  logic [ADDR_WIDTH-1:0] cur_q;

  assign rd_addr = cur_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
    end else if (launch) begin
      cur_q <= base_addr;
    end else if (ram_en) begin
      cur_q <= (cur_q == ADDR_WIDTH'(DEPTH-1)) ? '0 : cur_q + ADDR_WIDTH'(1);
    end
  end
`endif

  assign push   = in_flight_q;
  assign pop    = vld_q & m_ready;
  assign credit = {1'b0, cnt_q} + {2'b00, in_flight_q};
  // A word leaving this cycle frees its slot for the read issued now.
  assign ram_en = (state_q == S_READ) && ((credit - {2'b00, pop}) <= 3'd1);
  assign cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (launch) rem_d = len;
    else if (ram_en) rem_d = rem_q - (ADDR_WIDTH+1)'(1);
    case (state_q)
      S_IDLE:  if (start) state_d = (len == '0) ? S_DONE : S_READ;
      S_READ:  if (ram_en && rem_q == (ADDR_WIDTH+1)'(1)) state_d = S_DRAIN;
      S_DRAIN: if (cnt_d == 2'd0 && !in_flight_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      last_addr_q <= '0;
      in_flight_q <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      last_addr_q <= ram_addr;
      in_flight_q <= ram_en;
      if (push) begin
        buf_q[wr_ptr_q] <= ram_dout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
      vld_q <= (cnt_d != 2'd0);
    end
  end

  assign ram_addr = ram_en ? rd_addr : last_addr_q;
  assign m_valid  = vld_q;
  assign m_data   = buf_q[rd_ptr_q];
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_poly_ram_reader.sv
// Directed bench for poly_ram_reader: queue model of the expected read window plus literal timing/data checks.
`timescale 1ns/1ps
module tb_poly_ram_reader;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, ram_en, m_valid;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int exp_data[$];
  int exp_addr[$];
  int got_data[$];
  int got_addr[$];
  int issued = 0;
  int popped = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] ram_mem [DEPTH];

  always #5 clk = ~clk;

  poly_ram_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = DW'(i + 100);

  always @(posedge clk) if (ram_en) ram_dout <= ram_mem[ram_addr];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_load(input int b, input int l);
    got_data.delete();
    got_addr.delete();
    for (int i = 0; i < l; i++) begin
      exp_addr.push_back((b + i) % DEPTH);
      exp_data.push_back(((b + i) % DEPTH) + 100);
    end
  endtask

  function automatic logic rdy(input int mode, input int k);
    return (mode == 0) ? 1'b1 : ((k % 3) == 0);
  endfunction

  // Per-cycle check of the stream and read port against the expected window.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_data.delete();
      exp_addr.delete();
      issued = 0;
      popped = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (ram_en) begin
        chk("outstanding_le2", (issued - popped + 1 - int'(m_valid && m_ready)) <= 2, 1);
        if (exp_addr.size() == 0) chk("unexpected_read", ram_addr, -1);
        else chk("ram_addr", ram_addr, exp_addr.pop_front());
        got_addr.push_back(int'(ram_addr));
        issued++;
      end
      if (m_valid) begin
        if (exp_data.size() == 0) chk("unexpected_valid", m_data, -1);
        else chk("m_data", m_data, exp_data[0]);
        if (m_ready) begin
          if (exp_data.size() > 0) void'(exp_data.pop_front());
          got_data.push_back(int'(m_data));
          popped++;
        end
      end
      if (done) chk("done_all_delivered", exp_data.size() + exp_addr.size(), 0);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic run_txn(input int b, input int l, input int mode, input int inj_k, input int max_cyc,
                         output int t_first, output int t_last, output int t_done, output int n_vld,
                         output logic busy_after);
    t_first = -1; t_last = -1; t_done = -1; n_vld = 0;
    model_load(b, l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); len = (AW+1)'(l); m_ready = rdy(mode, 0);
    for (int k = 0; k < max_cyc && t_done < 0; k++) begin
      @(negedge clk);
      if (m_valid) begin
        n_vld++;
        if (t_first < 0) t_first = k;
        t_last = k;
      end
      if (done) t_done = k;
      @(posedge clk); #1;
      start     = (k + 1 == inj_k);
      base_addr = AW'($urandom);
      len       = (AW+1)'($urandom);
      m_ready   = rdy(mode, k + 1);
    end
    start = 1'b0;
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_m_data"}, m_data, 0);
  endtask

  initial begin
    int tf, tl, td, nv;
    logic ba;
    int wrap_addr[6] = '{1020, 1021, 1022, 1023, 0, 1};
    int wrap_data[6] = '{1120, 1121, 1122, 1123, 100, 101};
    int bp_data[4]   = '{100, 101, 102, 103};

    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // Basic window of 8 from address 0
    run_txn(0, 8, 0, -1, 40, tf, tl, td, nv, ba);
    chk("len8_first_valid", tf, 3);
    chk("len8_last_valid", tl, 10);
    chk("len8_valid_cycles", nv, 8);
    chk("len8_done_cycle", td, 11);
    chk("len8_busy_after", ba, 0);
    chk("len8_count", got_data.size(), 8);
    chk("len8_first_word", got_data[0], 100);
    chk("len8_last_word", got_data[7], 107);

    // Wrap at DEPTH
    run_txn(1020, 6, 0, -1, 40, tf, tl, td, nv, ba);
    chk("wrap_reads", got_addr.size(), 6);
    chk("wrap_words", got_data.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("wrap_addr", got_addr[i], wrap_addr[i]);
      chk("wrap_data", got_data[i], wrap_data[i]);
    end
    chk("wrap_done_cycle", td, 9);

    // Backpressure: m_ready high one cycle in three
    run_txn(0, 4, 1, -1, 60, tf, tl, td, nv, ba);
    chk("bp_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_data", got_data[i], bp_data[i]);
    chk("bp_busy_after", ba, 0);

    // Zero-length request
    run_txn(0, 0, 0, -1, 10, tf, tl, td, nv, ba);
    chk("len0_done_cycle", td, 1);
    chk("len0_valid_cycles", nv, 0);
    chk("len0_reads", got_addr.size(), 0);

    // start while busy must be ignored
    run_txn(0, 8, 0, 4, 40, tf, tl, td, nv, ba);
    chk("busy_start_done_cycle", td, 11);
    chk("busy_start_count", got_data.size(), 8);
    chk("busy_start_last_word", got_data[7], 107);
    chk("busy_start_idle_after", ba, 0);

    // Reset in cycle 5 of a 16-word read
    model_load(0, 16);
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; len = (AW+1)'(16); m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(10, 2, 0, -1, 20, tf, tl, td, nv, ba);
    chk("post_reset_count", got_data.size(), 2);
    chk("post_reset_word0", got_data[0], 110);
    chk("post_reset_word1", got_data[1], 111);
    chk("post_reset_first_valid", tf, 3);
    chk("post_reset_done_cycle", td, 5);

    // Full-depth window
    run_txn(5, DEPTH, 0, -1, 1100, tf, tl, td, nv, ba);
    chk("full_valid_cycles", nv, 1024);
    chk("full_first_valid", tf, 3);
    chk("full_last_valid", tl, 1026);
    chk("full_done_cycle", td, 1027);
    chk("full_reads", got_addr.size(), 1024);
    chk("full_first_addr", got_addr[0], 5);
    chk("full_addr_top", got_addr[1018], 1023);
    chk("full_addr_wrap", got_addr[1019], 0);
    chk("full_last_addr", got_addr[1023], 4);
    chk("full_last_word", got_data[1023], 104);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/poly_ram_reader.md
Name: poly_ram_reader

Overview:
- Read-side companion to the circular shift/delay RAM writers in the NewHope datapath.
- Drains a window of `len` entries from a dual-port RAM read port, starting at `base_addr` and wrapping at DEPTH.
- Presents the entries as a valid/ready stream to downstream NTT or pointwise units.
- Hides the 1-cycle RAM read latency with a 2-entry output buffer, so throughput is 1 word/cycle under continuous `m_ready`.

Parameters:
- DATA_WIDTH, 32, RAM word width and stream data width
- DEPTH, 1024, number of RAM entries; also the address wrap point
- ADDR_WIDTH, $clog2(DEPTH), RAM address width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- base_addr  input  ADDR_WIDTH  first address to read; sampled with `start`
- len  input  ADDR_WIDTH+1  number of words to read, 0..DEPTH; sampled with `start`
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse once the last word has been accepted downstream
- ram_en  output  1  RAM read enable
- ram_addr  output  ADDR_WIDTH  RAM read address
- ram_dout  input  DATA_WIDTH  RAM read data, valid on the cycle after `ram_en`
- m_valid  output  1  stream valid
- m_data  output  DATA_WIDTH  stream data
- m_ready  input  1  stream ready

Behaviour:
- Reset (async, `rst_n`=0):
  - State goes to IDLE.
  - `busy`, `done`, `ram_en`, `m_valid` = 0; `ram_addr`, `m_data` = 0.
  - Buffer is emptied and the in-flight flag is cleared.
  - Reset mid-operation discards all pending data; no `done` is produced.
- FSM states:
  - IDLE: `start`=1 with `len`≠0 → READ; latch `base_addr`, remaining=`len`, offset=0. `start`=1 with `len`=0 → DONE.
  - READ: issue reads, one per cycle. The read after the final one is issued goes to DRAIN.
  - DRAIN: wait until the buffer is empty and nothing is in flight, then go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. `base_addr` and `len` are don't-care except in the `start` cycle.
- Read issue:
  - `ram_en`=1 in READ when occupancy + in_flight + 1 ≤ 2, counting the pop in the same cycle (`m_valid`&&`m_ready`) as freeing a slot.
  - `ram_addr` = (base + offset) mod DEPTH, wrapped by compare-and-reset, not by bit truncation; DEPTH need not be a power of two.
  - `ram_addr` holds its last value when `ram_en`=0.
- Capture: `ram_dout` is written into the buffer on the cycle after each `ram_en`=1, unconditionally, because credit is guaranteed.
- Stream:
  - `m_valid` = buffer non-empty, driven from a register; buffer order is FIFO.
  - `m_data` is stable while `m_valid`=1 and `m_ready`=0.
  - Transfer occurs when `m_valid`&&`m_ready`.
- Latency: `start` in cycle 0 → `ram_en` in cycle 1 → `ram_dout` captured at the end of cycle 2 → `m_valid` first high in cycle 3.
- Throughput: with `m_ready` held at 1, `m_valid` stays high for exactly `len` consecutive cycles. `done` is asserted 1 cycle after the last transfer (DRAIN→DONE).
- `len`=DEPTH reads every entry once, ending at `base_addr`-1 mod DEPTH.
- A simultaneous push and pop in the same cycle leaves occupancy unchanged.

Optional Feature:
- Macro: POLY_RAM_READER_BITREV_EN.
- Defined:
  - `ram_addr` = (base + bitrev(offset)) mod 2^ADDR_WIDTH, where bitrev reverses all ADDR_WIDTH bits of offset. This produces the NTT input order.
  - DEPTH must equal 2^ADDR_WIDTH; generate a compile-time error otherwise.
- Undefined: linear order as described in Behaviour; no bit-reversal logic is generated.

Test Plan:
- Preload RAM[i]=i+100 with DEPTH=1024. `start`, `base_addr`=0, `len`=8, `m_ready`=1 → `m_valid` high in cycles 3..10 carrying 100..107; `done` in cycle 11; `busy` low in cycle 12.
- Wrap: `base_addr`=1020, `len`=6 → data 1120,1121,1122,1123,100,101; `ram_addr` sequence 1020..1023,0,1.
- Backpressure: `len`=4, `m_ready` toggling 1,0,0,1,… → each word held stable while stalled; never more than 2 reads outstanding plus buffered; order 100..103 with no loss or duplication.
- `len`=0 → `done` pulse in cycle 1; `ram_en` and `m_valid` never assert. `start` pulsed during busy → ignored; the current transfer completes unchanged.
- Reset mid-operation: `rst_n` low in cycle 5 of a `len`=16 read → all outputs 0 immediately. A new `start` with `len`=2 then yields only the 2 new words, with no stale data.
- With POLY_RAM_READER_BITREV_EN, DEPTH=8, `base_addr`=0, `len`=8 → `ram_addr` order 0,4,2,6,1,5,3,7.
